br_mask_ctrl: RTL and testbench

- Branch-mask allocator and resolver for the R10K-style out-of-order core.
- Each in-flight branch gets one bit of a BR_MASK_W-bit mask.
- Dispatch reads the current mask (br_mask_o) into ROB/stacks as the new branch's dependency mask. When the ROB resolves a branch, this block identifies the branch bit, frees it, and broadcasts it to the RS.
- On a mispredict, the block also frees every younger branch that depends on the mispredicted one.

---
 rtl/br_mask_ctrl.sv | 49 ++++
 tb/tb_br_mask_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/br_mask_ctrl.sv
// br_mask_ctrl: branch-mask allocator/resolver; ports clk, rst, is_br_i, br_state_i, br_dep_mask_i -> br_mask_o, br_bit_o, full_o
module br_mask_ctrl #(
  parameter int BR_MASK_W = 5,
  parameter int BR_STATE_W = 2,
  parameter logic [BR_STATE_W-1:0] BR_PR_NONE = 2'b00,
  parameter logic [BR_STATE_W-1:0] BR_PR_CORRECT = 2'b01,
  parameter logic [BR_STATE_W-1:0] BR_PR_WRONG = 2'b10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_br_i,
  input  logic [BR_STATE_W-1:0] br_state_i,
  input  logic [BR_MASK_W-1:0]  br_dep_mask_i,
  output logic [BR_MASK_W-1:0]  br_mask_o,
  output logic [BR_MASK_W-1:0]  br_bit_o,
  output logic                  full_o
);
  logic [BR_MASK_W-1:0] mask;
  logic [BR_MASK_W-1:0] dep [BR_MASK_W];
  logic [BR_MASK_W-1:0] match, free, alloc, dependents, clr;
  logic resolving, wrong;
  assign resolving = br_state_i == BR_PR_CORRECT || br_state_i == BR_PR_WRONG;
  always_comb begin
    match = '0;
    dependents = '0;
    for (int k = 0; k < BR_MASK_W; k++)
      match[k] = mask[k] && dep[k] == br_dep_mask_i;
    br_bit_o = resolving ? match & (~match + 1'b1) : '0;
    for (int j = 0; j < BR_MASK_W; j++)
      dependents[j] = |(dep[j] & br_bit_o);
  end
  // A real mispredict squashes its dependents and the branch dispatched alongside it.
  assign wrong = br_state_i == BR_PR_WRONG && |br_bit_o;
  assign clr = wrong ? br_bit_o | dependents : br_bit_o;
  assign free = ~mask;
  assign alloc = is_br_i && !full_o && !wrong ? free & (~free + 1'b1) : '0;
  assign full_o = &mask;
  assign br_mask_o = mask;
  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
      for (int k = 0; k < BR_MASK_W; k++) dep[k] <= '0;
    end else begin
      mask <= (mask & ~clr) | alloc;
      for (int k = 0; k < BR_MASK_W; k++)
        if (alloc[k]) dep[k] <= mask;
    end
  end
endmodule

// File: tb/tb_br_mask_ctrl.sv
module tb_br_mask_ctrl;
  logic clk = 0, rst = 1, is_br = 0;
  logic [1:0] st = 0;
  logic [4:0] depi = 0;
  logic [4:0] br_mask, br_bit;
  logic full;
  int vecs = 0, errs = 0;
  bit live [5];
  logic [4:0] mdep [5];
  logic [4:0] lb;

  br_mask_ctrl dut (.clk(clk), .rst(rst), .is_br_i(is_br), .br_state_i(st),
                    .br_dep_mask_i(depi), .br_mask_o(br_mask), .br_bit_o(br_bit), .full_o(full));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] mmask();
    logic [4:0] m = '0;
    for (int i = 0; i < 5; i++) m[i] = live[i];
    return m;
  endfunction

  function automatic int find_k(input logic [1:0] s, input logic [4:0] d);
    if (s != 2'b01 && s != 2'b10) return -1;
    for (int i = 0; i < 5; i++) if (live[i] && mdep[i] == d) return i;
    return -1;
  endfunction

  task automatic step(input logic b, input logic [1:0] s, input logic [4:0] d, input logic r = 0);
    int k, a;
    bit all_live;
    logic [4:0] om;
    @(negedge clk);
    is_br = b; st = s; depi = d; rst = r;
    #1;
    k = find_k(s, d);
    lb = br_bit;
    chk("br_bit", br_bit, k >= 0 ? 5'(1 << k) : 5'b0);
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 5; i++) begin live[i] = 0; mdep[i] = '0; end
    end else begin
      om = mmask();
      all_live = om == 5'b11111;
      a = -1;
      if (b && !all_live && !(s == 2'b10 && k >= 0))
        for (int i = 4; i >= 0; i--) if (!live[i]) a = i;
      if (k >= 0) begin
        if (s == 2'b10)
          for (int j = 0; j < 5; j++) if (mdep[j][k]) live[j] = 0;
        live[k] = 0;
      end
      if (a >= 0) begin live[a] = 1; mdep[a] = om; end
    end
    chk("mask", br_mask, mmask());
    chk("full", {4'b0, full}, {4'b0, mmask() == 5'b11111});
  endtask

  initial begin
    logic [4:0] d;
    int pick;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset_mask", br_mask, 5'b00000);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("idle_mask", br_mask, 5'b00000);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    chk("fill_mask", br_mask, 5'b11111);
    chk("fill_full", {4'b0, full}, 5'b00001);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    chk("held_mask", br_mask, 5'b11111);
    step(0, 2'b01, 5'b00011);
    chk("corr1_bit", lb, 5'b00100);
    chk("corr1_mask", br_mask, 5'b11011);
    step(0, 2'b01, 5'b01111);
    chk("corr2_bit", lb, 5'b10000);
    chk("corr2_mask", br_mask, 5'b01011);
    step(0, 2'b10, 5'b00001);
    chk("wrong_bit", lb, 5'b00010);
    chk("wrong_mask", br_mask, 5'b00001);
    step(0, 2'b00, 5'b00001);
    chk("none_bit", lb, 5'b00000);
    step(1, 2'b01, 5'b00000);
    chk("simul_bit", lb, 5'b00001);
    chk("simul_mask", br_mask, 5'b00010);
    step(0, 2'b01, 5'b11100);
    chk("nomatch_bit", lb, 5'b00000);
    chk("nomatch_mask", br_mask, 5'b00010);
    step(0, 2'b11, 5'b00000);
    chk("reserved_mask", br_mask, 5'b00010);
    for (int n = 0; n < 400; n++) begin
      d = 5'($urandom);
      pick = $urandom_range(0, 4);
      if ($urandom_range(0, 3) != 0 && live[pick]) d = mdep[pick];
      step(1'($urandom_range(0, 2) != 0), 2'($urandom), d, $urandom_range(0, 99) == 0);
    end
    step(1, 2'b01, 5'b00000, 1);
    chk("midrst_mask", br_mask, 5'b00000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
